// File: rtl/timer_pkg.sv
// Shared constants and the digit clamp used by the cascaded BCD countdown timer.
package timer_pkg;

    localparam int DIG_W = 4;
    localparam logic [15:0] DIGIT_MOD_MMSS = 16'h6A6A;

    // Out-of-range or non-BCD digits saturate to the largest legal value, MOD-1.
    function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] val,
                                                     input logic [DIG_W-1:0] mod);
        return (val >= mod) ? (mod - 4'd1) : val;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One mod-MOD BCD down-counting digit with clamped parallel load and borrow chaining.
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [DIG_W-1:0] MOD = 4'd10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [DIG_W-1:0] d,
    input  logic             bin,
    output logic [DIG_W-1:0] q,
    output logic             bout
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= clamp_digit(d, MOD);
        end else if (bin) begin
            q <= (q == '0) ? (MOD - 4'd1) : (q - 4'd1);
        end
    end

    assign bout = bin & (q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit cascaded BCD down-counter with saturate-at-zero, done pulse and optional reload.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int          NDIG      = 4,
    parameter logic [31:0] DIGIT_MOD = 32'(DIGIT_MOD_MMSS),
    parameter int          RELOAD    = 0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  loadn,
    input  logic                  en,
    input  logic [DIG_W*NDIG-1:0] data,
    output logic [DIG_W*NDIG-1:0] count,
    output logic                  zero,
    output logic                  tc,
    output logic                  done
);

    localparam int W = DIG_W * NDIG;

    logic [NDIG:0] borrow;
    logic          reload_now;
    logic          load_any;
    logic          done_next;

    assign zero       = (count == '0);
    assign tc         = en & zero;
    assign reload_now = (RELOAD != 0) && en && zero;
    assign load_any   = ~loadn | reload_now;
    assign borrow[0]  = en & ~zero & loadn;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            bcd_digit_down #(
                .MOD (DIGIT_MOD[gi*DIG_W +: DIG_W])
            ) u_digit (
                .clk  (clk),
                .clr  (clr),
                .load (load_any),
                .d    (data[gi*DIG_W +: DIG_W]),
                .bin  (borrow[gi]),
                .q    (count[gi*DIG_W +: DIG_W]),
                .bout (borrow[gi+1])
            );
        end
    endgenerate

    // Reaching zero by decrement means count was exactly 1; a top borrow would be an underflow.
    assign done_next = borrow[0] & (count == W'(1)) & ~borrow[NDIG];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            done <= 1'b0;
        end else begin
            done <= done_next;
        end
    end

endmodule
